// File: rtl/pcie_rx_tag_pkg.sv
// Shared definitions for the PCIe RX completion-tag tracker: default widths,
// the per-slot state record and the completion timeout limit.
// Optional build macro: PCIE_CPL_TIMEOUT_EN (per-slot completion timeout).
package pcie_rx_tag_pkg;

  localparam int C_PCIE_DATA_WIDTH_DEF  = 512;
  localparam int P_FIFO_DEPTH_WIDTH_DEF = 5;
  localparam int P_NUM_TAGS_DEF         = 6;
  localparam int P_TAG_WIDTH_DEF        = 3;
  localparam int P_LEN_WIDTH_DEF        = 3;

  // Age at which an incomplete slot is force-completed.
  localparam logic [15:0] CPL_TIMEOUT_LIMIT = 16'hFFFF;

  // State held for one outstanding read tag (default widths).
  typedef struct packed {
    logic                              valid;
    logic [P_TAG_WIDTH_DEF-1:0]        id;
    logic [P_FIFO_DEPTH_WIDTH_DEF:0]   base;
    logic [P_LEN_WIDTH_DEF-1:0]        len;
    logic [P_LEN_WIDTH_DEF-1:0]        rcvd;
  } tag_slot_t;

endpackage

// File: rtl/pcie_cpld_tag_slot.sv
// One tracked tag slot: stores id/base/len, counts received beats, and
// reports tag match, accepting hit, completion and its next write address.
// Optional build macro: PCIE_CPL_TIMEOUT_EN adds an age counter and timeout_o.
module pcie_cpld_tag_slot
  import pcie_rx_tag_pkg::*;
#(
  parameter int P_FIFO_DEPTH_WIDTH = P_FIFO_DEPTH_WIDTH_DEF,
  parameter int P_TAG_WIDTH        = P_TAG_WIDTH_DEF,
  parameter int P_LEN_WIDTH        = P_LEN_WIDTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          load_i,
  input  logic [P_TAG_WIDTH-1:0]        load_id_i,
  input  logic [P_FIFO_DEPTH_WIDTH:0]   load_base_i,
  input  logic [P_LEN_WIDTH-1:0]        load_len_i,
  input  logic                          clear_i,
  input  logic                          beat_i,
  input  logic [P_TAG_WIDTH-1:0]        cpld_tag_i,
  output logic                          match_o,
  output logic                          hit_o,
  output logic                          complete_o,
  output logic [P_FIFO_DEPTH_WIDTH-1:0] wr_addr_o,
  output logic [P_FIFO_DEPTH_WIDTH:0]   end_addr_o
`ifdef PCIE_CPL_TIMEOUT_EN
  ,output logic                         timeout_o
`endif
);

  localparam int AW = P_FIFO_DEPTH_WIDTH;

  logic                   valid_q;
  logic [P_TAG_WIDTH-1:0] id_q;
  logic [AW:0]            base_q;
  logic [P_LEN_WIDTH-1:0] len_q;
  logic [P_LEN_WIDTH-1:0] rcvd_q;
  logic                   force_done;

  assign match_o    = valid_q && (id_q == cpld_tag_i);
  assign hit_o      = match_o && (rcvd_q != len_q);
  assign complete_o = valid_q && (rcvd_q == len_q);
  assign wr_addr_o  = base_q[AW-1:0] + AW'(rcvd_q);
  assign end_addr_o = base_q + (AW+1)'(len_q);

`ifdef PCIE_CPL_TIMEOUT_EN
  logic [15:0] age_q;

  // A slot still waiting for beats ages; the limit forces it complete so the ring drains.
  assign force_done = valid_q && !complete_o && !beat_i && (age_q == CPL_TIMEOUT_LIMIT);
  assign timeout_o  = force_done;

  // Age restarts on allocation and on every accepted beat.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      age_q <= '0;
    end else if (load_i || beat_i) begin
      age_q <= '0;
    end else if (valid_q && !complete_o && (age_q != CPL_TIMEOUT_LIMIT)) begin
      age_q <= age_q + 16'd1;
    end
  end
`else
  assign force_done = 1'b0;
`endif

  // Slot registers: load on alloc, clear on release, count beats otherwise.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      base_q  <= '0;
      len_q   <= '0;
      rcvd_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      id_q    <= load_id_i;
      base_q  <= load_base_i;
      len_q   <= load_len_i;
      rcvd_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (beat_i) begin
      rcvd_q  <= rcvd_q + P_LEN_WIDTH'(1);
    end else if (force_done) begin
      rcvd_q  <= len_q;
    end
  end

endmodule

// File: rtl/pcie_cpld_tag_tracker.sv
// Completion-tag reassembly: tracks outstanding read tags in allocation
// order, steers completion beats into each tag's FIFO region and releases
// FIFO space strictly in allocation order.
// Optional build macro: PCIE_CPL_TIMEOUT_EN (adds err_timeout output).
//
// Handshakes: tag_alloc is accepted on an edge where tag_full_n=1 and
// tag_alloc_len!=0, otherwise it is dropped; cpld_wr_en is always accepted
// (no backpressure), its effect appears on the outputs one cycle later.
module pcie_cpld_tag_tracker
  import pcie_rx_tag_pkg::*;
#(
  parameter int C_PCIE_DATA_WIDTH  = C_PCIE_DATA_WIDTH_DEF,
  parameter int P_FIFO_DEPTH_WIDTH = P_FIFO_DEPTH_WIDTH_DEF,
  parameter int P_NUM_TAGS         = P_NUM_TAGS_DEF,
  parameter int P_TAG_WIDTH        = P_TAG_WIDTH_DEF,
  parameter int P_LEN_WIDTH        = P_LEN_WIDTH_DEF
) (
  input  logic                          pcie_user_clk,
  input  logic                          pcie_user_rst_n,
  input  logic                          tag_alloc,
  input  logic [7:0]                    tag_alloc_id,
  input  logic [P_LEN_WIDTH-1:0]        tag_alloc_len,
  output logic                          tag_full_n,
  input  logic                          cpld_wr_en,
  input  logic [7:0]                    cpld_tag,
  input  logic [C_PCIE_DATA_WIDTH-1:0]  cpld_data,
  output logic                          fifo_wr_en,
  output logic [P_FIFO_DEPTH_WIDTH-1:0] fifo_wr_addr,
  output logic [C_PCIE_DATA_WIDTH-1:0]  fifo_wr_data,
  output logic [P_FIFO_DEPTH_WIDTH:0]   rear_full_addr,
  output logic [P_FIFO_DEPTH_WIDTH:0]   rear_addr,
  output logic                          err_unexp_tag,
  output logic                          err_overrun
`ifdef PCIE_CPL_TIMEOUT_EN
  ,output logic                         err_timeout
`endif
);

  localparam int AW = P_FIFO_DEPTH_WIDTH;
  localparam int NT = P_NUM_TAGS;
  localparam int IW = (NT > 1) ? $clog2(NT) : 1;

  logic [IW-1:0] alloc_idx_q, alloc_idx_d, rel_idx_q, rel_idx_d;
  logic          alloc_wrap_q, alloc_wrap_d, rel_wrap_q, rel_wrap_d;
  logic [AW:0]   rear_full_q, rear_full_d, rear_q, rear_d;
  logic          wr_en_q, wr_en_d, unexp_q, unexp_d, over_q, over_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [C_PCIE_DATA_WIDTH-1:0] wr_data_q;

  logic [NT-1:0] slot_match, slot_hit, slot_complete, slot_sel;
  logic [AW-1:0] slot_wr_addr [NT];
  logic [AW:0]   slot_end     [NT];
  logic          alloc_ok, head_complete;
  logic [AW-1:0] hit_addr;
  logic [NT-1:0] hit_v;

  // Upper tag bits take no part in slot lookup.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{tag_alloc_id[7:P_TAG_WIDTH], cpld_tag[7:P_TAG_WIDTH]};

  assign tag_full_n    = !((alloc_idx_q == rel_idx_q) && (alloc_wrap_q != rel_wrap_q));
  assign alloc_ok      = tag_alloc && tag_full_n && (tag_alloc_len != '0);
  assign head_complete = slot_complete[rel_idx_q];
  assign hit_v         = cpld_wr_en ? slot_hit : '0;
  assign slot_sel      = hit_v & (~hit_v + NT'(1));

`ifdef PCIE_CPL_TIMEOUT_EN
  logic [NT-1:0] slot_timeout;
  logic          timeout_q;
`endif

  for (genvar g = 0; g < NT; g++) begin : g_slot
    pcie_cpld_tag_slot #(
      .P_FIFO_DEPTH_WIDTH(P_FIFO_DEPTH_WIDTH),
      .P_TAG_WIDTH       (P_TAG_WIDTH),
      .P_LEN_WIDTH       (P_LEN_WIDTH)
    ) u_slot (
      .clk_i      (pcie_user_clk),
      .rst_n_i    (pcie_user_rst_n),
      .load_i     (alloc_ok && (alloc_idx_q == IW'(g))),
      .load_id_i  (tag_alloc_id[P_TAG_WIDTH-1:0]),
      .load_base_i(rear_full_q),
      .load_len_i (tag_alloc_len),
      .clear_i    (head_complete && (rel_idx_q == IW'(g))),
      .beat_i     (slot_sel[g]),
      .cpld_tag_i (cpld_tag[P_TAG_WIDTH-1:0]),
      .match_o    (slot_match[g]),
      .hit_o      (slot_hit[g]),
      .complete_o (slot_complete[g]),
      .wr_addr_o  (slot_wr_addr[g]),
      .end_addr_o (slot_end[g])
`ifdef PCIE_CPL_TIMEOUT_EN
      ,.timeout_o (slot_timeout[g])
`endif
    );
  end

  // One-hot select of the winning slot's write address.
  always_comb begin
    hit_addr = '0;
    for (int i = 0; i < NT; i++) begin
      if (slot_sel[i]) hit_addr = hit_addr | slot_wr_addr[i];
    end
  end

  // Ring pointers, FIFO pointers and the next output-stage values.
  always_comb begin
    alloc_idx_d  = alloc_idx_q;
    alloc_wrap_d = alloc_wrap_q;
    rel_idx_d    = rel_idx_q;
    rel_wrap_d   = rel_wrap_q;
    rear_full_d  = rear_full_q;
    rear_d       = rear_q;
    if (alloc_ok) begin
      alloc_idx_d = (alloc_idx_q == IW'(NT-1)) ? '0 : alloc_idx_q + IW'(1);
      if (alloc_idx_q == IW'(NT-1)) alloc_wrap_d = !alloc_wrap_q;
      rear_full_d = rear_full_q + (AW+1)'(tag_alloc_len);
    end
    if (head_complete) begin
      rel_idx_d = (rel_idx_q == IW'(NT-1)) ? '0 : rel_idx_q + IW'(1);
      if (rel_idx_q == IW'(NT-1)) rel_wrap_d = !rel_wrap_q;
      rear_d = slot_end[rel_idx_q];
    end
    wr_en_d   = |slot_sel;
    wr_addr_d = hit_addr;
    unexp_d   = cpld_wr_en && !(|slot_match);
    over_d    = cpld_wr_en && (|slot_match) && !(|slot_hit);
  end

  // Pointer and output-stage registers.
  always_ff @(posedge pcie_user_clk) begin
    if (!pcie_user_rst_n) begin
      alloc_idx_q  <= '0;
      alloc_wrap_q <= 1'b0;
      rel_idx_q    <= '0;
      rel_wrap_q   <= 1'b0;
      rear_full_q  <= '0;
      rear_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      unexp_q      <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      alloc_idx_q  <= alloc_idx_d;
      alloc_wrap_q <= alloc_wrap_d;
      rel_idx_q    <= rel_idx_d;
      rel_wrap_q   <= rel_wrap_d;
      rear_full_q  <= rear_full_d;
      rear_q       <= rear_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      unexp_q      <= unexp_d;
      over_q       <= over_d;
    end
  end

  // Beat payload is captured only when it will actually be written.
  always_ff @(posedge pcie_user_clk) begin
    if (|slot_sel) wr_data_q <= cpld_data;
  end

`ifdef PCIE_CPL_TIMEOUT_EN
  // Any slot timing out this cycle raises a one-cycle flag.
  always_ff @(posedge pcie_user_clk) begin
    if (!pcie_user_rst_n) timeout_q <= 1'b0;
    else                  timeout_q <= |slot_timeout;
  end
  assign err_timeout = timeout_q;
`endif

  assign fifo_wr_en     = wr_en_q;
  assign fifo_wr_addr   = wr_addr_q;
  assign fifo_wr_data   = wr_data_q;
  assign rear_full_addr = rear_full_q;
  assign rear_addr      = rear_q;
  assign err_unexp_tag  = unexp_q;
  assign err_overrun    = over_q;

endmodule

// File: tb/tb_pcie_cpld_tag_tracker.sv
// Self-checking bench for pcie_cpld_tag_tracker: directed scenarios with
// literal expectations plus randomized traffic against a queue-based model.
module tb_pcie_cpld_tag_tracker;

  localparam int DW = 512;
  localparam int AW = 5;
  localparam int NT = 6;
  localparam int TW = 3;
  localparam int LW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          tag_alloc;
  logic [7:0]    tag_alloc_id;
  logic [LW-1:0] tag_alloc_len;
  logic          tag_full_n;
  logic          cpld_wr_en;
  logic [7:0]    cpld_tag;
  logic [DW-1:0] cpld_data;
  logic          fifo_wr_en;
  logic [AW-1:0] fifo_wr_addr;
  logic [DW-1:0] fifo_wr_data;
  logic [AW:0]   rear_full_addr;
  logic [AW:0]   rear_addr;
  logic          err_unexp_tag;
  logic          err_overrun;
`ifdef PCIE_CPL_TIMEOUT_EN
  logic          err_timeout;
`endif

  pcie_cpld_tag_tracker #(
    .C_PCIE_DATA_WIDTH (DW),
    .P_FIFO_DEPTH_WIDTH(AW),
    .P_NUM_TAGS        (NT),
    .P_TAG_WIDTH       (TW),
    .P_LEN_WIDTH       (LW)
  ) dut (
    .pcie_user_clk  (clk),
    .pcie_user_rst_n(rst_n),
    .tag_alloc      (tag_alloc),
    .tag_alloc_id   (tag_alloc_id),
    .tag_alloc_len  (tag_alloc_len),
    .tag_full_n     (tag_full_n),
    .cpld_wr_en     (cpld_wr_en),
    .cpld_tag       (cpld_tag),
    .cpld_data      (cpld_data),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_wr_addr   (fifo_wr_addr),
    .fifo_wr_data   (fifo_wr_data),
    .rear_full_addr (rear_full_addr),
    .rear_addr      (rear_addr),
    .err_unexp_tag  (err_unexp_tag),
    .err_overrun    (err_overrun)
`ifdef PCIE_CPL_TIMEOUT_EN
    ,.err_timeout   (err_timeout)
`endif
  );

  // ---------------- model / scoreboard ----------------
  typedef struct {
    int tag;
    int base;
    int len;
    int rcvd;
  } ent_t;

  ent_t          mq[$];       // outstanding tags, oldest first
  int            m_rear_full;
  int            m_rear;
  bit            e_wr, e_unexp, e_over;
  int            e_addr;
  logic [DW-1:0] e_data;

  logic [AW-1:0] exp_q[$];    // literal write-address sequence for directed tests
  bit            track_addr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Advance the model by one clock edge using the inputs presented before it.
  task automatic model_step();
    bit rel;
    int cnt;
    int hit_j;
    bit seen;
    e_wr = 0; e_unexp = 0; e_over = 0;
    if (!rst_n) begin
      mq.delete();
      m_rear_full = 0;
      m_rear = 0;
      return;
    end
    rel = (mq.size() > 0) && (mq[0].rcvd == mq[0].len);
    cnt = mq.size();
    if (cpld_wr_en) begin
      hit_j = -1;
      seen  = 0;
      for (int j = 0; j < mq.size(); j++) begin
        if ((mq[j].tag % 8) == (int'(cpld_tag) % 8)) begin
          seen = 1;
          if (mq[j].rcvd < mq[j].len && hit_j < 0) hit_j = j;
        end
      end
      if (hit_j >= 0) begin
        e_wr   = 1;
        e_addr = (mq[hit_j].base + mq[hit_j].rcvd) % 32;
        e_data = cpld_data;
        mq[hit_j].rcvd++;
      end else if (seen) begin
        e_over = 1;
      end else begin
        e_unexp = 1;
      end
    end
    if (tag_alloc && cnt < NT && tag_alloc_len != 0) begin
      mq.push_back('{tag: int'(tag_alloc_id), base: m_rear_full, len: int'(tag_alloc_len), rcvd: 0});
      m_rear_full = (m_rear_full + int'(tag_alloc_len)) % 64;
    end
    if (rel) begin
      m_rear = (mq[0].base + mq[0].len) % 64;
      void'(mq.pop_front());
    end
  endtask

  // Compare every DUT output against the model after each edge.
  task automatic compare();
    chk("fifo_wr_en", fifo_wr_en, e_wr);
    if (e_wr) begin
      chk("fifo_wr_addr", fifo_wr_addr, e_addr);
      chk("fifo_wr_data", fifo_wr_data, e_data);
    end
    chk("err_unexp_tag", err_unexp_tag, e_unexp);
    chk("err_overrun", err_overrun, e_over);
    chk("rear_full_addr", rear_full_addr, m_rear_full);
    chk("rear_addr", rear_addr, m_rear);
    chk("tag_full_n", tag_full_n, mq.size() < NT);
`ifdef PCIE_CPL_TIMEOUT_EN
    chk("err_timeout", err_timeout, 0);
`endif
    if (track_addr && fifo_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL addr_seq_extra actual=%0d expected=none", fifo_wr_addr);
      end else begin
        chk("addr_seq", fifo_wr_addr, exp_q.pop_front());
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    tag_alloc = 0; tag_alloc_id = '0; tag_alloc_len = '0;
    cpld_wr_en = 0; cpld_tag = '0; cpld_data = '0;
  endtask

  task automatic do_cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
    set_idle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic reset_dut();
    rst_n = 0;
    do_cycle();
    do_cycle();
    rst_n = 1;
  endtask

  task automatic alloc(input int id, input int len);
    tag_alloc = 1; tag_alloc_id = 8'(id); tag_alloc_len = LW'(len);
    do_cycle();
  endtask

  task automatic beat(input int tag);
    cpld_wr_en = 1; cpld_tag = 8'(tag); cpld_data = rand_data();
    do_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int free_tags[$];
    int open_tags[$];
    m_rear_full = 0; m_rear = 0;
    e_wr = 0; e_unexp = 0; e_over = 0; e_addr = 0; e_data = '0;
    track_addr = 0;
    set_idle();
    reset_dut();
    chk("rst_tag_full_n", tag_full_n, 1);
    chk("rst_rear_full", rear_full_addr, 0);
    chk("rst_rear", rear_addr, 0);
    chk("rst_wr_en", fifo_wr_en, 0);

    // Fill all six slots with len-2 tags.
    for (int t = 0; t < 6; t++) alloc(t, 2);
    chk("fill_full_n", tag_full_n, 0);
    chk("fill_rear_full", rear_full_addr, 12);
    alloc(6, 2);
    chk("fill_7th_ignored", rear_full_addr, 12);

    // Out-of-order completion: tag 1 first, then tag 0.
    track_addr = 1;
    exp_q.push_back(5'd2); exp_q.push_back(5'd3);
    exp_q.push_back(5'd0); exp_q.push_back(5'd1);
    beat(1); beat(1); beat(0); beat(0);
    chk("ooo_rear_hold", rear_addr, 0);
    do_cycle();
    chk("ooo_rear_first", rear_addr, 2);
    do_cycle();
    chk("ooo_rear_second", rear_addr, 4);
    chk("ooo_seq_drained", exp_q.size(), 0);
    track_addr = 0;

    // Unexpected tag.
    reset_dut();
    beat(7);
    chk("unexp_pulse", err_unexp_tag, 1);
    chk("unexp_no_write", fifo_wr_en, 0);
    do_cycle();
    chk("unexp_one_cycle", err_unexp_tag, 0);

    // Overrun: len 1, two beats.
    alloc(2, 1);
    beat(2);
    chk("over_first_write", fifo_wr_en, 1);
    beat(2);
    chk("over_pulse", err_overrun, 1);
    chk("over_no_write", fifo_wr_en, 0);
    idle(2);

    // FIFO address wrap: base 30, len 3.
    reset_dut();
    for (int t = 0; t < 4; t++) alloc(t, 7);
    alloc(4, 2);
    alloc(5, 3);
    chk("wrap_rear_full", rear_full_addr, 33);
    track_addr = 1;
    exp_q.push_back(5'd30); exp_q.push_back(5'd31); exp_q.push_back(5'd0);
    beat(5); beat(5); beat(5);
    chk("wrap_seq_drained", exp_q.size(), 0);
    track_addr = 0;
    for (int t = 0; t < 4; t++) for (int k = 0; k < 7; k++) beat(t);
    beat(4); beat(4);
    idle(8);
    chk("wrap_rear", rear_addr, 6'b100001);
    chk("wrap_full_n", tag_full_n, 1);

    // Reset in the middle of a burst.
    for (int t = 0; t < 3; t++) alloc(t, 4);
    beat(0); beat(1);
    rst_n = 0;
    cpld_wr_en = 1; cpld_tag = 8'd2; cpld_data = rand_data();
    tag_alloc = 1; tag_alloc_id = 8'd3; tag_alloc_len = 3'd2;
    do_cycle();
    chk("midrst_wr_en", fifo_wr_en, 0);
    chk("midrst_full_n", tag_full_n, 1);
    chk("midrst_rear_full", rear_full_addr, 0);
    rst_n = 1;
    beat(0);
    chk("midrst_unexp", err_unexp_tag, 1);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) rst_n = 0;
      else rst_n = 1;
      free_tags.delete();
      open_tags.delete();
      for (int t = 0; t < 8; t++) begin
        bit used = 0;
        foreach (mq[j]) if ((mq[j].tag % 8) == t) used = 1;
        if (!used) free_tags.push_back(t);
      end
      foreach (mq[j]) if (mq[j].rcvd < mq[j].len) open_tags.push_back(mq[j].tag % 8);
      if ($urandom_range(0, 2) == 0 && free_tags.size() > 0) begin
        tag_alloc = 1;
        tag_alloc_id = {5'($urandom), 3'(free_tags[$urandom_range(0, free_tags.size() - 1)])};
        tag_alloc_len = LW'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 1) == 0) begin
        cpld_wr_en = 1;
        cpld_data = rand_data();
        if (open_tags.size() > 0 && $urandom_range(0, 19) != 0)
          cpld_tag = {5'($urandom), 3'(open_tags[$urandom_range(0, open_tags.size() - 1)])};
        else
          cpld_tag = 8'($urandom);
      end
      do_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_cpld_tag_tracker.md
Name: pcie_cpld_tag_tracker

Overview:
- Parametrised next-generation completion-tag reassembly block for the PCIe RX path, sitting between the CplD parser and the dual-port PRP/data FIFO.
- Tracks N outstanding read tags in allocation order and steers out-of-order completion beats to each tag's reserved FIFO region.
- Releases FIFO space strictly in allocation order.
- Adds beat counting against requested length, unexpected-tag and overrun error reporting, and simultaneous multi-event handling.

Parameters:
- C_PCIE_DATA_WIDTH, 512, completion data beat width.
- P_FIFO_DEPTH_WIDTH, 5, log2 of FIFO depth in beats.
- P_NUM_TAGS, 6, tracked tag slots (2..16).
- P_TAG_WIDTH, 3, low tag bits compared (log2 of P_NUM_TAGS rounded up, or more).
- P_LEN_WIDTH, 3, width of the allocation length field; a length is 1..2^P_LEN_WIDTH-1 beats.

Ports:
- pcie_user_clk  in  1  clock.
- pcie_user_rst_n  in  1  synchronous active-low reset.
- tag_alloc  in  1  allocate request, one cycle per tag.
- tag_alloc_id  in  8  PCIe tag issued with the MRd.
- tag_alloc_len  in  P_LEN_WIDTH  beats requested.
- tag_full_n  out  1  slot available (low = all slots busy).
- cpld_wr_en  in  1  completion beat valid.
- cpld_tag  in  8  tag of the beat.
- cpld_data  in  C_PCIE_DATA_WIDTH  beat payload.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_addr  out  P_FIFO_DEPTH_WIDTH  FIFO write address.
- fifo_wr_data  out  C_PCIE_DATA_WIDTH  FIFO write data.
- rear_full_addr  out  P_FIFO_DEPTH_WIDTH+1  allocation pointer, with wrap bit.
- rear_addr  out  P_FIFO_DEPTH_WIDTH+1  committed (released) pointer, with wrap bit.
- err_unexp_tag  out  1  one-cycle pulse: beat matched no valid slot.
- err_overrun  out  1  one-cycle pulse: beat exceeded the slot's length.

Behaviour:
- Reset (synchronous, pcie_user_rst_n=0 at the clock edge):
  - all slots are invalid;
  - the alloc and release slot pointers are 0, with wrap bits 0;
  - rear_full_addr=0 and rear_addr=0;
  - fifo_wr_en=0 and both error outputs are 0;
  - tag_full_n=1.
- Reset mid-operation discards all in-flight tags. fifo_wr_addr and fifo_wr_data are don't-care while fifo_wr_en=0.
- Slot ring: the alloc pointer and the release pointer are indices with a wrap bit.
  - tag_full_n = NOT(indices equal AND wrap bits differ). It is combinational from registers.
- Alloc:
  - tag_alloc=1 with tag_full_n=1 loads the slot at the alloc pointer: id, base=rear_full_addr, len, rcvd=0, valid=1.
  - It also advances the alloc pointer and adds len to rear_full_addr (modulo 2^(P_FIFO_DEPTH_WIDTH+1)).
  - Alloc while full, or with len=0, is ignored with no state change. FIFO space checking is the requester's responsibility.
- Completion beat: a slot hits when it is valid, its id[P_TAG_WIDTH-1:0] equals cpld_tag[P_TAG_WIDTH-1:0], and rcvd<len.
  - Multiple hits cannot occur (unique tags); the lowest index wins.
  - On a hit: one cycle later fifo_wr_en=1, fifo_wr_addr=(base+rcvd)[P_FIFO_DEPTH_WIDTH-1:0], and fifo_wr_data is the registered cpld_data. rcvd increments in the same edge.
  - A valid slot with matching id and rcvd==len: the beat is dropped, and err_overrun pulses one cycle later.
  - No matching valid slot: the beat is dropped, and err_unexp_tag pulses one cycle later.
- A slot allocated at edge k cannot be hit by a beat presented in the cycle before edge k; it is valid from cycle k+1.
- Release:
  - When the slot at the release pointer is valid with rcvd==len, at the next edge: the slot is cleared, the release pointer advances, and rear_addr = base+len of that slot.
  - At most one release per cycle, so back-to-back completed slots release on consecutive cycles.
  - A slot completed out of order waits until all older slots have released.
- Simultaneous events:
  - Alloc, beat and release in the same cycle are all honoured.
  - Alloc into the slot being released in that cycle is not allowed: that slot is still busy, so full was asserted.
  - A beat completing the head slot is visible to release in the next cycle (release latency is 1 cycle after the last write strobe).

Optional Feature:
- PCIE_CPL_TIMEOUT_EN defined:
  - each valid slot has a 16-bit age counter, reset on alloc and on each beat;
  - on reaching 16'hFFFF the slot is force-completed (rcvd:=len, no data written);
  - err_timeout (extra output, 1 bit) pulses one cycle, so the ring never deadlocks.
- Undefined: no counters, no err_timeout port; a missing completion stalls release indefinitely.

Decomposition:
- Shared package pcie_rx_tag_pkg holds:
  - default widths;
  - the slot-state struct typedef (valid, id, base, len, rcvd);
  - the timeout limit constant.
- One natural sub-module, pcie_cpld_tag_slot: per-slot registers, hit compare, rcvd counter and complete flag. The top holds the ring pointers, the hit priority mux, the output register stage and release.

Test Plan:
- Reset, then 6 allocs (tags 0..5, len 2 each) -> tag_full_n=0 after the 6th; rear_full_addr=12; a 7th alloc is ignored.
- Tag 1 beats A,B, then tag 0 beats C,D -> FIFO writes at addresses 2,3,0,1. rear_addr stays 0 until tag 0 completes, then goes 2 and 4 on two consecutive cycles.
- Beat with tag 7, none allocated -> no fifo_wr_en; err_unexp_tag pulses one cycle after the beat.
- Tag 2, len 1, receives 2 beats -> one write; err_overrun pulses on the second beat.
- Wrap: P_FIFO_DEPTH_WIDTH=5, base 30, len 3 -> writes at 30,31,0; rear_addr=6'b100001 after release.
- Reset asserted mid-burst -> next edge: all outputs at reset values, tag_full_n=1; subsequent beats flag err_unexp_tag.
